// File: rtl/instr_fetch_pkg.sv
// Shared widths, fetch FSM states and queue entry layout for the instruction fetch unit.
package instr_fetch_pkg;
  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;
  localparam int QDEPTH  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Two-entry in-order fetch queue; slot 0 is always the head, pops shift the tail forward.
module fetch_queue
  import instr_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [1:0]   count
);
  fetch_entry_t slot_reg  [QDEPTH];
  fetch_entry_t slot_next [QDEPTH];
  logic [1:0]   count_reg;
  logic [1:0]   count_next;
  logic [1:0]   wr_idx;
  logic         pop_ok;
  logic         push_ok;

  // Flush wins over both push and pop, so a flushed head counts as not consumed.
  assign pop_ok  = pop && (count_reg != 2'd0) && !flush;
  assign push_ok = push && !flush && ((count_reg != 2'(QDEPTH)) || pop_ok);
  assign wr_idx  = count_reg - {1'b0, pop_ok};

  for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_slot
    fetch_entry_t shift_src;
    if (gi < QDEPTH - 1) begin : g_shift
      assign shift_src = slot_reg[gi+1];
    end else begin : g_last
      assign shift_src = slot_reg[gi];
    end
    assign slot_next[gi] = (push_ok && (wr_idx == 2'(gi))) ? push_data :
                           (pop_ok ? shift_src : slot_reg[gi]);
  end

  assign count_next = flush ? 2'd0 : (count_reg + {1'b0, push_ok} - {1'b0, pop_ok});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= 2'd0;
      for (int i = 0; i < QDEPTH; i++) slot_reg[i] <= '0;
    end else begin
      count_reg <= count_next;
      for (int i = 0; i < QDEPTH; i++) slot_reg[i] <= slot_next[i];
    end
  end

  assign head  = (count_reg != 2'd0) ? slot_reg[0] : '0;
  assign count = count_reg;
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, single-outstanding request FSM with redirect drop, feeding a fetch_queue.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_en,
  input  logic [ADDR_W-1:0]  redirect_addr,
  input  logic               id_ready,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc
);
  fetch_state_t      state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] req_pc_reg;
  logic [1:0]        q_count;
  fetch_entry_t      q_head;
  fetch_entry_t      q_push_data;
  logic              issue;
  logic              q_push;
  logic              q_pop;

  // Issuing only with count < 2 keeps count + outstanding within the queue depth.
  assign issue       = rst_n && (state_reg == IDLE) && (q_count < 2'd2) && !redirect_en;
  assign q_push      = (state_reg == WAIT) && imem_valid && !redirect_en;
  assign q_pop       = (q_count != 2'd0) && id_ready;
  assign q_push_data = '{instr: imem_rdata, pc: req_pc_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      pc_reg     <= RESET_PC;
      req_pc_reg <= '0;
    end else begin
      if (redirect_en)
        pc_reg <= redirect_addr;
      else if (issue)
        pc_reg <= pc_reg + ADDR_W'(1);
      if (issue)
        req_pc_reg <= pc_reg;
      case (state_reg)
        IDLE: if (issue) state_reg <= WAIT;
        // A redirect with the response already here just discards it and goes idle.
        WAIT: begin
          if (imem_valid)       state_reg <= IDLE;
          else if (redirect_en) state_reg <= DROP;
        end
        DROP: if (imem_valid) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  fetch_queue u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (q_pop),
    .flush     (redirect_en),
    .head      (q_head),
    .count     (q_count)
  );

  assign imem_req  = issue;
  assign imem_addr = pc_reg;
  assign if_valid  = (q_count != 2'd0);
  assign if_instr  = q_head.instr;
  assign if_pc     = q_head.pc;
endmodule
